clint_multi: RTL

Parametrised core-local interruptor with a memory-mapped 64-bit machine timer, per-hart `mtimecmp` and software-interrupt (`msip`) registers for `NUM_HARTS` harts. Sits on the CPU data bus beside RAM/peripherals, answering the same `DV` handshake the load/store unit drives. Produces level timer and software interrupt lines per hart that feed each core's interrupt logic, replacing the standalone timer stub.

---
 rtl/clint_pkg.sv | 13 +
 rtl/clint_prescaler.sv | 33 +++
 rtl/clint_multi.sv | 137 +++++++++++++
 3 files changed

// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - CLINT register map offsets, window size and reset constants
package clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_LO_OFF = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF = 16'hBFFC;

  localparam logic [31:0] WINDOW_SIZE  = 32'h0001_0000;
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [2:0]  BHW_WORD     = 3'b100;

endpackage

// File: rtl/clint_prescaler.sv
// rtl/clint_prescaler.sv - mtime tick generator, one tick every TIMER_DIV cycles
module clint_prescaler #(
  parameter int TIMER_DIV = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMER_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  assign o_tick = (count_q == LAST);

  always_comb begin
    count_d = count_q + 1'b1;
    if (i_clr || o_tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/clint_multi.sv
// rtl/clint_multi.sv - multi-hart CLINT bus slave; CLINT_PRESCALER_EN enables the mtime prescaler
module clint_multi
  import clint_pkg::*;
#(
  parameter int          NUM_HARTS = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TIMER_DIV = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [31:0]          i_bus_address,
  input  logic [31:0]          i_bus_data,
  input  logic                 i_bus_DV,
  input  logic                 i_write_notread,
  input  logic [2:0]           i_bhw,
  output logic [31:0]          o_bus_data,
  output logic                 o_bus_DV,
  output logic [NUM_HARTS-1:0] o_timer_int,
  output logic [NUM_HARTS-1:0] o_soft_int
);

  logic [63:0]          mtime_q, mtime_d;
  logic [31:0]          shadow_q, shadow_d;
  logic [63:0]          mtimecmp_q [NUM_HARTS];
  logic [63:0]          mtimecmp_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q, msip_d;
  logic [NUM_HARTS-1:0] timer_int_q, timer_int_d;
  logic                 bus_dv_q, bus_dv_d;
  logic [31:0]          bus_data_q, bus_data_d;

  logic [31:0] off;
  logic [15:0] msip_rel, cmp_rel;
  logic        claim, aligned, msip_hit, cmp_hit, word_wr, rd;
  logic        mtime_lo_hit, mtime_hi_hit, mtime_wr, tick;
  logic [3:0]  msip_idx, cmp_idx;

  // Any in-window request is acknowledged; only aligned mapped words are decoded.
  assign off          = i_bus_address - BASE_ADDR;
  assign claim        = i_bus_DV && (off < WINDOW_SIZE);
  assign aligned      = (off[1:0] == 2'b00);
  assign msip_rel     = off[15:0] - MSIP_OFF;
  assign cmp_rel      = off[15:0] - MTIMECMP_OFF;
  assign msip_hit     = aligned && (msip_rel < 16'(4 * NUM_HARTS));
  assign cmp_hit      = aligned && (cmp_rel < 16'(8 * NUM_HARTS));
  assign msip_idx     = msip_rel[5:2];
  assign cmp_idx      = cmp_rel[6:3];
  assign mtime_lo_hit = (off[15:0] == MTIME_LO_OFF);
  assign mtime_hi_hit = (off[15:0] == MTIME_HI_OFF);
  assign word_wr      = claim && i_write_notread && (i_bhw == BHW_WORD);
  assign rd           = claim && !i_write_notread;
  assign mtime_wr     = word_wr && (mtime_lo_hit || mtime_hi_hit);

`ifdef CLINT_PRESCALER_EN
  clint_prescaler #(
    .TIMER_DIV (TIMER_DIV)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (mtime_wr),
    .o_tick  (tick)
  );
`else
  logic unused_timer_div;
  assign unused_timer_div = (TIMER_DIV > 0);
  assign tick             = 1'b1;
`endif

  always_comb begin
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    shadow_d   = shadow_q;
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    bus_dv_d   = claim;
    bus_data_d = '0;

    // A software write to either half suppresses that cycle's tick entirely.
    if (mtime_wr) begin
      if (mtime_hi_hit) begin
        mtime_d = {i_bus_data, mtime_q[31:0]};
      end else begin
        mtime_d = {mtime_q[63:32], i_bus_data};
      end
    end

    if (rd && mtime_lo_hit) begin
      bus_data_d = mtime_q[31:0];
      shadow_d   = mtime_q[63:32];
    end else if (rd && mtime_hi_hit) begin
      bus_data_d = shadow_q;
    end

    for (int h = 0; h < NUM_HARTS; h++) begin
      if (msip_hit && msip_idx == 4'(h)) begin
        if (word_wr) msip_d[h] = i_bus_data[0];
        if (rd)      bus_data_d = {31'd0, msip_q[h]};
      end
      if (cmp_hit && cmp_idx == 4'(h)) begin
        if (cmp_rel[2]) begin
          if (word_wr) mtimecmp_d[h][63:32] = i_bus_data;
          if (rd)      bus_data_d = mtimecmp_q[h][63:32];
        end else begin
          if (word_wr) mtimecmp_d[h][31:0] = i_bus_data;
          if (rd)      bus_data_d = mtimecmp_q[h][31:0];
        end
      end
      timer_int_d[h] = (mtime_q >= mtimecmp_q[h]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mtime_q     <= '0;
      shadow_q    <= '0;
      msip_q      <= '0;
      timer_int_q <= '0;
      bus_dv_q    <= 1'b0;
      bus_data_q  <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtimecmp_q[h] <= MTIMECMP_RST;
      end
    end else begin
      mtime_q     <= mtime_d;
      shadow_q    <= shadow_d;
      msip_q      <= msip_d;
      timer_int_q <= timer_int_d;
      bus_dv_q    <= bus_dv_d;
      bus_data_q  <= bus_data_d;
      mtimecmp_q  <= mtimecmp_d;
    end
  end

  assign o_bus_DV    = bus_dv_q;
  assign o_bus_data  = bus_data_q;
  assign o_timer_int = timer_int_q;
  assign o_soft_int  = msip_q;

endmodule
